// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - parametrised data/valid/ready FIFO with level, almost-full and flush
// All handshake and status outputs are flops loaded from the next-cycle count.
module stream_fifo #(
   parameter  int WIDTH       = 8,
   parameter  int DEPTH       = 4,
   parameter  int AFULL_LEVEL = DEPTH - 1,
   localparam int LW          = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [LW-1:0]    o_level,
   output logic             o_almost_full
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    cnt;
   logic [LW-1:0]    cnt_next;
   logic             push;
   logic             pop;

   assign push = i_valid & o_ready;
   assign pop  = o_valid & i_ready;

   always_comb begin
      cnt_next = cnt + LW'(push) - LW'(pop);
   end

   // Head entry is a pure mux over storage flops; no input reaches it combinationally.
   assign o_data = mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         o_valid       <= 1'b0;
         o_ready       <= 1'b0;
         o_level       <= '0;
         o_almost_full <= 1'b0;
      end else if (i_flush) begin
         // A same-cycle pop has already transferred the head; a same-cycle push is dropped.
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         o_valid       <= 1'b0;
         o_ready       <= 1'b1;
         o_level       <= '0;
         o_almost_full <= (AFULL_LEVEL == 0);
      end else begin
         if (push) begin
            mem[wr_ptr] <= i_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         cnt           <= cnt_next;
         o_valid       <= (cnt_next != '0);
         o_ready       <= (cnt_next != LW'(DEPTH));
         o_level       <= cnt_next;
         o_almost_full <= (cnt_next >= LW'(AFULL_LEVEL));
      end
   end

endmodule
